// File: rtl/syn_ram_bank.sv
// ---------------------------------------------------------------------------
// syn_ram_bank
// Single-clock RAM bank with byte-lane writes, a registered read port and a
// self-clearing sweep that fills every word with INIT_VALUE. The sweep runs
// out of reset and on request; user accesses during the sweep are dropped
// and flagged on err.
//
// Parameters
//   DATA_WIDTH : word width in bits (multiple of 8)
//   ADDR_WIDTH : address width, DEPTH = 2**ADDR_WIDTH
//   RDW_MODE   : same-address read-during-write, 0 = old data, 1 = new data
//   INIT_VALUE : value written to every word by the clear sweep
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   init_req : request a full-memory clear sweep
//   busy     : clear sweep in progress
//   wr_en    : write strobe
//   wr_be    : byte-lane write enables (bit k -> data[8k+7:8k])
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe
//   rd_addr  : read address
//   rd_data  : registered read data
//   rd_valid : one-cycle pulse, rd_data valid
//   err      : one-cycle pulse, access attempted while busy
// ---------------------------------------------------------------------------
module syn_ram_bank #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_req,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    err
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam int                    NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [DATA_WIDTH-1:0]   w_old_word;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    // Merge the new write data into the stored word lane by lane. The same
    // merged word feeds the memory and the write-first read bypass.
    always_comb begin
        w_old_word = r_mem[wr_addr];
        w_merged   = w_old_word;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (wr_be[k]) begin
                w_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // The sweep owns the write port while clearing; user writes only get
    // through in IDLE and only when at least one lane is enabled.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = wr_addr;
        w_mem_wdata = w_merged;
        if (r_state == CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = INIT_VALUE;
        end else if (wr_en && (|wr_be)) begin
            w_mem_we = 1'b1;
        end
    end

    // Storage has no reset; it is emptied by the sweep instead. Writes are
    // suppressed while rst is held so an aborted sweep leaves no side effects.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Control FSM with registered outputs. Reset parks the FSM in CLEAR at
    // address 0 so the sweep starts on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rd_en) begin
                        r_rd_valid <= 1'b1;
                        // Write-first bypass returns the merged word on a
                        // same-address collision; otherwise the stored word.
                        if ((RDW_MODE != 0) && wr_en && (wr_addr == rd_addr)) begin
                            r_rd_data <= w_merged;
                        end else begin
                            r_rd_data <= r_mem[rd_addr];
                        end
                    end
                    if (init_req) begin
                        r_state    <= CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    r_err      <= wr_en | rd_en;
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

endmodule

// File: tb/tb_syn_ram_bank.sv
// ---------------------------------------------------------------------------
// tb_syn_ram_bank
// Directed bench for syn_ram_bank. Two instances share every input: dut0 uses
// the defaults (read-first, INIT_VALUE 0) and dut1 is write-first with a
// non-zero INIT_VALUE so both collision modes and the clear value are seen.
// ---------------------------------------------------------------------------
module tb_syn_ram_bank;

    localparam logic [15:0] INIT1 = 16'h5A5A;

    logic        clk;
    logic        rst;
    logic        initReq;
    logic        wrEn;
    logic [1:0]  wrBe;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    logic        rdEn;
    logic [3:0]  rdAddr;

    logic        busy0, rdValid0, err0;
    logic [15:0] rdData0;
    logic        busy1, rdValid1, err1;
    logic [15:0] rdData1;

    int nAsserts;
    int nFails;
    int nCycles;

    syn_ram_bank #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .INIT_VALUE(16'h0000)
    ) dut0 (
        .clk(clk), .rst(rst), .init_req(initReq), .busy(busy0),
        .wr_en(wrEn), .wr_be(wrBe), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData0),
        .rd_valid(rdValid0), .err(err0)
    );

    syn_ram_bank #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1), .INIT_VALUE(INIT1)
    ) dut1 (
        .clk(clk), .rst(rst), .init_req(initReq), .busy(busy1),
        .wr_en(wrEn), .wr_be(wrBe), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData1),
        .rd_valid(rdValid1), .err(err1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all request inputs at once; called just after an active edge.
    task automatic applyStimulus(input logic iInit, input logic iWrEn,
                                 input logic [1:0] iBe, input logic [3:0] iWrAddr,
                                 input logic [15:0] iWrData, input logic iRdEn,
                                 input logic [3:0] iRdAddr);
        initReq = iInit;
        wrEn    = iWrEn;
        wrBe    = iBe;
        wrAddr  = iWrAddr;
        wrData  = iWrData;
        rdEn    = iRdEn;
        rdAddr  = iRdAddr;
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One immediate-assertion comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Count edges until busy drops on dut0, bounded to avoid hanging.
    task automatic countBusy(input int startCount, input int limit, output int total);
        total = startCount;
        while (busy0 === 1'b1 && total < limit) begin
            tick();
            total++;
        end
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy0", 32'(busy0), 32'd1);
        checkOutput("rst_busy1", 32'(busy1), 32'd1);
        checkOutput("rst_rdData0", 32'(rdData0), 32'h0);
        checkOutput("rst_rdValid0", 32'(rdValid0), 32'd0);
        checkOutput("rst_err0", 32'(err0), 32'd0);

        // Release: sweep lasts exactly 16 edges
        rst = 1'b0;
        countBusy(0, 40, nCycles);
        checkOutput("initSweepLen", 32'(nCycles), 32'd16);
        checkOutput("initSweepBusy1", 32'(busy1), 32'd0);

        // Every word holds the clear value, read latency 1
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'(a));
            tick();
            checkOutput($sformatf("clrRdValid0_%0d", a), 32'(rdValid0), 32'd1);
            checkOutput($sformatf("clrRdData0_%0d", a), 32'(rdData0), 32'h0000);
            checkOutput($sformatf("clrRdData1_%0d", a), 32'(rdData1), 32'(INIT1));
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        tick();
        checkOutput("idleRdValid0", 32'(rdValid0), 32'd0);
        checkOutput("holdRdData1", 32'(rdData1), 32'(INIT1));

        // Byte-lane merge: ABCD then low lane 34 -> AB34
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h3, 16'hABCD, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h3, 16'h1234, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h3);
        tick();
        checkOutput("laneMerge0", 32'(rdData0), 32'hAB34);
        checkOutput("laneMerge1", 32'(rdData1), 32'hAB34);

        // Same-address read during write
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h5, 16'h1111, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h5, 16'h2222, 1'b1, 4'h5);
        tick();
        checkOutput("rdwReadFirst", 32'(rdData0), 32'h1111);
        checkOutput("rdwWriteFirst", 32'(rdData1), 32'h2222);
        checkOutput("rdwValid1", 32'(rdValid1), 32'd1);

        // wr_be=0 is a silent no-op
        applyStimulus(1'b0, 1'b1, 2'b00, 4'h5, 16'hFFFF, 1'b0, 4'h0);
        tick();
        checkOutput("beZeroErr0", 32'(err0), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h5);
        tick();
        checkOutput("afterRdw0", 32'(rdData0), 32'h2222);
        checkOutput("afterRdw1", 32'(rdData1), 32'h2222);

        // Different addresses in the same cycle
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h6, 16'h6666, 1'b1, 4'h3);
        tick();
        checkOutput("diffAddrRd0", 32'(rdData0), 32'hAB34);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h6);
        tick();
        checkOutput("diffAddrWr0", 32'(rdData0), 32'h6666);
        checkOutput("diffAddrWr1", 32'(rdData1), 32'h6666);

        // init_req in IDLE with a same-cycle read that still completes
        applyStimulus(1'b1, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h3);
        tick();
        checkOutput("initBusy0", 32'(busy0), 32'd1);
        checkOutput("initRdValid0", 32'(rdValid0), 32'd1);
        checkOutput("initRdData0", 32'(rdData0), 32'hAB34);
        checkOutput("initErr0", 32'(err0), 32'd0);

        // Write during the sweep: dropped, err pulses once
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h7, 16'h7777, 1'b0, 4'h0);
        tick();
        checkOutput("sweepErr0", 32'(err0), 32'd1);
        checkOutput("sweepErr1", 32'(err1), 32'd1);
        checkOutput("sweepNoValid0", 32'(rdValid0), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        tick();
        checkOutput("sweepErrOnce0", 32'(err0), 32'd0);

        // A repeated init_req mid-sweep must not restart it
        applyStimulus(1'b1, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        countBusy(3, 60, nCycles);
        checkOutput("reqSweepLen", 32'(nCycles), 32'd16);

        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h7);
        tick();
        checkOutput("addr7Init0", 32'(rdData0), 32'h0000);
        checkOutput("addr7Init1", 32'(rdData1), 32'(INIT1));
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h3);
        tick();
        checkOutput("addr3Init1", 32'(rdData1), 32'(INIT1));

        // Load rd_data with a non-zero word, then abort a sweep by reset
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h9, 16'h9999, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h9);
        tick();
        checkOutput("preRstRd0", 32'(rdData0), 32'h9999);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        checkOutput("midSweepBusy0", 32'(busy0), 32'd1);
        checkOutput("sweepHoldRd0", 32'(rdData0), 32'h9999);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h9);
        #1;
        checkOutput("abortBusy0", 32'(busy0), 32'd1);
        checkOutput("abortRdData0", 32'(rdData0), 32'h0000);
        checkOutput("abortRdValid0", 32'(rdValid0), 32'd0);
        tick();
        tick();
        checkOutput("abortHoldValid0", 32'(rdValid0), 32'd0);
        checkOutput("abortHoldData1", 32'(rdData1), 32'h0000);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        rst = 1'b0;
        countBusy(0, 40, nCycles);
        checkOutput("restartSweepLen", 32'(nCycles), 32'd16);

        // Back-to-back reads of 2 then 9, then hold
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h2, 16'h0C02, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h9, 16'h0C09, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h2);
        tick();
        checkOutput("b2bValidA", 32'(rdValid0), 32'd1);
        checkOutput("b2bDataA", 32'(rdData0), 32'h0C02);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 4'h9);
        tick();
        checkOutput("b2bValidB", 32'(rdValid0), 32'd1);
        checkOutput("b2bDataB", 32'(rdData0), 32'h0C09);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 4'h0);
        tick();
        checkOutput("b2bValidEnd", 32'(rdValid0), 32'd0);
        checkOutput("b2bHold0", 32'(rdData0), 32'h0C09);
        checkOutput("b2bHold1", 32'(rdData1), 32'h0C09);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
